// File: rtl/dcpu_exec_stage.sv
// dcpu16 execute stage: latches op/b/a, drives the external ALU, holds mul/div
// for MULDIV_LAT extra cycles, owns EX, and runs the IFx skip / chained-skip machine.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_valid/in_ready, in_op/b/a/dst    instruction handshake from operand fetch
//   alu_op/b/a/exin                     registered operands and EX to the ALU
//   alu_q/exout/cl/eq/lt/un             ALU result, EX result and compare flags
//   wb_valid/wb_ready, wb_q/wb_dst      result handshake to writeback
//   ex_wr_en/ex_wr_data                 direct EX write (wins over ALU EX)
//   ex_q                                EX register
//   skipping                            high while in SKIP
//   perf_retired/perf_skipped           only with DCPU_EXEC_PERF_EN defined
module dcpu_exec_stage #(
  parameter int MULDIV_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [15:0] in_b,
  input  logic [15:0] in_a,
  input  logic [5:0]  in_dst,
  output logic [4:0]  alu_op,
  output logic [15:0] alu_b,
  output logic [15:0] alu_a,
  output logic [15:0] alu_exin,
  input  logic [15:0] alu_q,
  input  logic [15:0] alu_exout,
  input  logic        alu_cl,
  input  logic        alu_eq,
  input  logic        alu_lt,
  input  logic        alu_un,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [15:0] wb_q,
  output logic [5:0]  wb_dst,
  input  logic        ex_wr_en,
  input  logic [15:0] ex_wr_data,
  output logic [15:0] ex_q,
  output logic        skipping
`ifdef DCPU_EXEC_PERF_EN
  ,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_skipped
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_SKIP = 2'd3;

  localparam int CW =
    (MULDIV_LAT > 0) ? $clog2(MULDIV_LAT + 1) : 1;
  localparam logic [CW-1:0] CNT_MD = CW'(MULDIV_LAT);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    op_q, op_d;
  logic [15:0]   b_q, b_d;
  logic [15:0]   a_q, a_d;
  logic [5:0]    dst_q, dst_d;
  logic [15:0]   res_q, res_d;
  logic [5:0]    tag_q, tag_d;
  logic [15:0]   exr_q, exr_d;

  logic in_is_if, in_is_md;
  logic op_is_if, op_ex_upd;
  logic cond;
  logic [15:0] res;
  logic done;

  assign in_is_if = (in_op[4:3] == 2'b10);
  assign in_is_md = (in_op >= 5'h04) && (in_op <= 5'h09);
  assign op_is_if = (op_q[4:3] == 2'b10);
  assign op_ex_upd =
    ((op_q >= 5'h02) && (op_q <= 5'h07)) ||
    ((op_q >= 5'h0D) && (op_q <= 5'h0F)) ||
    (op_q == 5'h1A) || (op_q == 5'h1B);

  assign done = (state_q == S_EXEC) && (cnt_q == '0);

  always_comb begin
    cond = 1'b0;
    case (op_q[2:0])
      3'd0: cond = !alu_cl;
      3'd1: cond = alu_cl;
      3'd2: cond = alu_eq;
      3'd3: cond = !alu_eq;
      3'd4: cond = !alu_eq && !alu_lt;
      3'd5: cond = !alu_eq && !alu_un;
      3'd6: cond = alu_lt;
      3'd7: cond = alu_un;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    res = '0;
    unique case (1'b1)
      op_q == 5'h01:
        res = a_q;
      (op_q >= 5'h02 && op_q <= 5'h0F),
      op_q == 5'h1A, op_q == 5'h1B:
        res = alu_q;
      default:
        res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    b_d     = b_q;
    a_d     = a_q;
    dst_d   = dst_q;
    res_d   = res_q;
    tag_d   = tag_q;
    exr_d   = exr_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          b_d     = in_b;
          a_d     = in_a;
          dst_d   = in_dst;
          cnt_d   = in_is_md ? CNT_MD : '0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (op_is_if) begin
          state_d = cond ? S_IDLE : S_SKIP;
        end else begin
          res_d   = res;
          tag_d   = dst_q;
          state_d = S_WB;
          if (op_ex_upd) exr_d = alu_exout;
        end
      end
      S_WB: begin
        if (wb_ready) state_d = S_IDLE;
      end
      S_SKIP: begin
        // a skipped IFx keeps the chain going
        if (in_valid) state_d = in_is_if ? S_SKIP : S_IDLE;
      end
    endcase
    if (ex_wr_en) exr_d = ex_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      b_q     <= '0;
      a_q     <= '0;
      dst_q   <= '0;
      res_q   <= '0;
      tag_q   <= '0;
      exr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      b_q     <= b_d;
      a_q     <= a_d;
      dst_q   <= dst_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
      exr_q   <= exr_d;
    end
  end

  assign in_ready = (state_q == S_IDLE) || (state_q == S_SKIP);
  assign skipping = (state_q == S_SKIP);
  assign wb_valid = (state_q == S_WB);
  assign wb_q     = res_q;
  assign wb_dst   = tag_q;
  assign alu_op   = op_q;
  assign alu_b    = b_q;
  assign alu_a    = a_q;
  assign alu_exin = exr_q;
  assign ex_q     = exr_q;

`ifdef DCPU_EXEC_PERF_EN
  logic [31:0] ret_q, ret_d;
  logic [31:0] skp_q, skp_d;

  always_comb begin
    ret_d = ret_q;
    skp_d = skp_q;
    if ((wb_valid && wb_ready) || (done && op_is_if))
      ret_d = ret_q + 32'd1;
    if (skipping && in_valid)
      skp_d = skp_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_q <= '0;
      skp_q <= '0;
    end else begin
      ret_q <= ret_d;
      skp_q <= skp_d;
    end
  end

  assign perf_retired = ret_q;
  assign perf_skipped = skp_q;
`else
  logic unused_done;
  assign unused_done = done;
`endif

endmodule

// File: tb/tb_dcpu_exec_stage.sv
// Bench for dcpu_exec_stage: behavioural ALU, scoreboard of writebacks,
// directed latency/skip/EX/reset cases plus a random instruction stream.
module tb_dcpu_exec_stage;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_op = '0;
  logic [15:0] in_b = '0;
  logic [15:0] in_a = '0;
  logic [5:0]  in_dst = '0;
  logic [4:0]  alu_op;
  logic [15:0] alu_b, alu_a, alu_exin;
  logic [15:0] alu_q, alu_exout;
  logic        alu_cl, alu_eq, alu_lt, alu_un;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [15:0] wb_q;
  logic [5:0]  wb_dst;
  logic        ex_wr_en = 1'b0;
  logic [15:0] ex_wr_data = '0;
  logic [15:0] ex_q;
  logic        skipping;
`ifdef DCPU_EXEC_PERF_EN
  logic [31:0] perf_retired, perf_skipped;
`endif

  always #5 clk = ~clk;

  dcpu_exec_stage #(.MULDIV_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_b(in_b), .in_a(in_a), .in_dst(in_dst),
    .alu_op(alu_op), .alu_b(alu_b), .alu_a(alu_a),
    .alu_exin(alu_exin), .alu_q(alu_q), .alu_exout(alu_exout),
    .alu_cl(alu_cl), .alu_eq(alu_eq), .alu_lt(alu_lt), .alu_un(alu_un),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_q(wb_q), .wb_dst(wb_dst),
    .ex_wr_en(ex_wr_en), .ex_wr_data(ex_wr_data),
    .ex_q(ex_q), .skipping(skipping)
`ifdef DCPU_EXEC_PERF_EN
    , .perf_retired(perf_retired), .perf_skipped(perf_skipped)
`endif
  );

  // ---- behavioural ALU: returns {exout, q}
  function automatic logic [31:0] alu_f(
    logic [4:0] op, logic [15:0] b, logic [15:0] a, logic [15:0] ex);
    logic [31:0] p;
    logic [17:0] s;
    logic [31:0] num;
    case (op)
      5'h02: begin
        s = {2'b0, b} + {2'b0, a};
        return {(s[16] ? 16'h0001 : 16'h0000), s[15:0]};
      end
      5'h03:
        return {((b < a) ? 16'hFFFF : 16'h0000), b - a};
      5'h04: begin
        p = {16'h0, b} * {16'h0, a};
        return p;
      end
      5'h06: begin
        if (a == 16'h0) return 32'h0;
        num = {b, 16'h0} / {16'h0, a};
        return {num[15:0], b / a};
      end
      5'h08:
        return (a == 16'h0) ? 32'h0 : {16'h0, b % a};
      5'h1A: begin
        s = {2'b0, b} + {2'b0, a} + {2'b0, ex};
        return {((s[17:16] != 2'b0) ? 16'h0001 : 16'h0000), s[15:0]};
      end
      default:
        return {16'h0, b ^ a};
    endcase
  endfunction

  logic [31:0] alu_r;
  always_comb begin
    alu_r     = alu_f(alu_op, alu_b, alu_a, alu_exin);
    alu_q     = alu_r[15:0];
    alu_exout = alu_r[31:16];
    alu_cl    = ((alu_b & alu_a) == 16'h0);
    alu_eq    = (alu_b == alu_a);
    alu_lt    = (alu_b < alu_a);
    alu_un    = ($signed(alu_b) < $signed(alu_a));
  end

  // ---- reference model of the stage
  function automatic bit is_ifx(logic [4:0] op);
    return (op >= 5'h10) && (op <= 5'h17);
  endfunction

  function automatic bit cond_f(
    logic [4:0] op, logic [15:0] b, logic [15:0] a);
    case (op)
      5'h10: return (b & a) != 16'h0;
      5'h11: return (b & a) == 16'h0;
      5'h12: return b == a;
      5'h13: return b != a;
      5'h14: return b > a;
      5'h15: return $signed(b) > $signed(a);
      5'h16: return b < a;
      default: return $signed(b) < $signed(a);
    endcase
  endfunction

  function automatic bit ex_upd(logic [4:0] op);
    return (op >= 5'h02 && op <= 5'h07) ||
           (op >= 5'h0D && op <= 5'h0F) ||
           op == 5'h1A || op == 5'h1B;
  endfunction

  function automatic logic [15:0] exp_wb(
    logic [4:0] op, logic [15:0] b, logic [15:0] a, logic [15:0] ex);
    logic [31:0] r;
    r = alu_f(op, b, a, ex);
    if (op == 5'h01) return a;
    if ((op >= 5'h02 && op <= 5'h0F) || op == 5'h1A || op == 5'h1B)
      return r[15:0];
    return 16'h0;
  endfunction

  typedef struct packed {
    logic [5:0]  dst;
    logic [15:0] q;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ex_m = '0;
  bit          skip_m = 0;
  int unsigned ret_m = 0;
  int unsigned skp_m = 0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    logic [4:0] op, logic [15:0] b, logic [15:0] a, logic [5:0] dst);
    int w;
    logic [31:0] r;
    w = 0;
    in_op = op; in_b = b; in_a = a; in_dst = dst;
    in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    if (!in_ready) chk("rdy_timeout", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (skip_m) begin
      skip_m = is_ifx(op);
      skp_m++;
    end else if (is_ifx(op)) begin
      skip_m = !cond_f(op, b, a);
      ret_m++;
    end else begin
      sb.push_back({dst, exp_wb(op, b, a, ex_m)});
      ret_m++;
      if (ex_upd(op)) begin
        r = alu_f(op, b, a, ex_m);
        ex_m = r[31:16];
      end
    end
  endtask

  task automatic wait_wb(output int lat);
    lat = 0;
    while (!wb_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    chk("idle_reached", {31'h0, in_ready}, 32'h1);
  endtask

  // scoreboard: a handshake seen at negedge completes on the next posedge
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && wb_valid && wb_ready) begin
      chk("wb_pending", {31'h0, sb.size() != 0}, 32'h1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wb_q", {16'h0, wb_q}, {16'h0, e.q});
        chk("wb_dst", {26'h0, wb_dst}, {26'h0, e.dst});
      end
    end
  end

  initial begin
    int lat;
    logic [4:0] ops [15];
    ops = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h06, 5'h08, 5'h0A,
            5'h10, 5'h11, 5'h12, 5'h14, 5'h15, 5'h16, 5'h17, 5'h1A};

    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_skipping", {31'h0, skipping}, 32'h0);
    chk("rst_ex_q", {16'h0, ex_q}, 32'h0);
    chk("rst_wb_q", {16'h0, wb_q}, 32'h0);
    chk("rst_wb_dst", {26'h0, wb_dst}, 32'h0);
    chk("rst_alu_op", {27'h0, alu_op}, 32'h0);

    // ADD FFFF+2: simple latency, EX carry
    send(5'h02, 16'hFFFF, 16'h0002, 6'd5);
    wait_wb(lat);
    chk("add_lat", lat, 32'd1);
    chk("add_wb_q", {16'h0, wb_q}, 32'h0001);
    chk("add_ex_q", {16'h0, ex_q}, 32'h0001);
    wait_idle();

    // DIV 7/2: stalls for MULDIV_LAT extra cycles
    send(5'h06, 16'h0007, 16'h0002, 6'd6);
    chk("div_busy0", {31'h0, in_ready}, 32'h0);
    wait_wb(lat);
    chk("div_lat", lat, 1 + LAT);
    chk("div_busy_wb", {31'h0, in_ready}, 32'h0);
    chk("div_wb_q", {16'h0, wb_q}, 32'h0003);
    wait_idle();
    chk("div_ex_q", {16'h0, ex_q}, {16'h0, ex_m});

    // IFE fails: next ADD discarded, SET runs
    send(5'h12, 16'h0005, 16'h0006, 6'd0);
    tick();
    chk("ife_skip", {31'h0, skipping}, 32'h1);
    send(5'h02, 16'h0001, 16'h0001, 6'd1);
    chk("skip_done", {31'h0, skipping}, 32'h0);
    chk("skip_ex", {16'h0, ex_q}, {16'h0, ex_m});
    send(5'h01, 16'h0000, 16'h0009, 6'd3);
    wait_wb(lat);
    chk("set9_wb_q", {16'h0, wb_q}, 32'h0009);
    wait_idle();

    // chained skip: IFN 1,1 fails, IFE 2,3 skipped, SET 7 dropped
    send(5'h13, 16'h0001, 16'h0001, 6'd0);
    tick();
    chk("ifn_skip", {31'h0, skipping}, 32'h1);
    send(5'h12, 16'h0002, 16'h0003, 6'd0);
    chk("chain_skip", {31'h0, skipping}, 32'h1);
    send(5'h01, 16'h0000, 16'h0007, 6'd7);
    chk("chain_end", {31'h0, skipping}, 32'h0);
    send(5'h01, 16'h0000, 16'h0008, 6'd8);
    wait_wb(lat);
    chk("set8_wb_q", {16'h0, wb_q}, 32'h0008);
    wait_idle();

    // SUB 0-1 with back-pressure; direct EX write wins on capture edge
    wb_ready = 1'b0;
    send(5'h03, 16'h0000, 16'h0001, 6'd9);
    ex_wr_en = 1'b1;
    ex_wr_data = 16'h1234;
    tick();
    ex_wr_en = 1'b0;
    ex_m = 16'h1234;
    chk("exwr_wins", {16'h0, ex_q}, 32'h1234);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", {31'h0, wb_valid}, 32'h1);
      chk("hold_q", {16'h0, wb_q}, 32'hFFFF);
      chk("hold_dst", {26'h0, wb_dst}, 32'd9);
      chk("hold_busy", {31'h0, in_ready}, 32'h0);
      tick();
    end
    wb_ready = 1'b1;
    wait_idle();

    // EX write while idle, then ADX consumes it through alu_exin
    ex_wr_en = 1'b1;
    ex_wr_data = 16'hABCD;
    tick();
    ex_wr_en = 1'b0;
    ex_m = 16'hABCD;
    chk("exwr_idle", {16'h0, ex_q}, 32'hABCD);
    send(5'h1A, 16'h0001, 16'h0002, 6'd4);
    wait_wb(lat);
    chk("adx_wb_q", {16'h0, wb_q}, 32'hABD0);
    wait_idle();

    // ops outside the result table write back zero
    send(5'h18, 16'h1111, 16'h2222, 6'd10);
    wait_idle();
    send(5'h1F, 16'h3333, 16'h4444, 6'd11);
    wait_idle();
    chk("undef_ex", {16'h0, ex_q}, {16'h0, ex_m});

    // random stream
    for (int i = 0; i < 40; i++) begin
      send(ops[$urandom_range(0, 14)],
           16'($urandom_range(0, 65535)),
           (i % 4 == 0) ? 16'h0000 : 16'($urandom_range(0, 65535)),
           6'($urandom_range(0, 63)));
      wait_idle();
      chk("rand_ex", {16'h0, ex_q}, {16'h0, ex_m});
      chk("rand_skip", {31'h0, skipping}, {31'h0, skip_m});
    end
    if (skip_m) begin
      send(5'h01, 16'h0, 16'h0, 6'd0);
      wait_idle();
    end

`ifdef DCPU_EXEC_PERF_EN
    chk("perf_ret", perf_retired, ret_m);
    chk("perf_skp", perf_skipped, skp_m);
`endif
    chk("sb_drained", sb.size(), 32'h0);

    // async reset in the middle of DIV
    ex_wr_en = 1'b1;
    ex_wr_data = 16'h5555;
    tick();
    ex_wr_en = 1'b0;
    send(5'h06, 16'h0009, 16'h0003, 6'd12);
    tick();
    rst_n = 1'b0;
    #2;
    chk("arst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("arst_ex_q", {16'h0, ex_q}, 32'h0);
    chk("arst_ready", {31'h0, in_ready}, 32'h1);
`ifdef DCPU_EXEC_PERF_EN
    chk("arst_perf_ret", perf_retired, 32'h0);
    chk("arst_perf_skp", perf_skipped, 32'h0);
`endif
    sb.delete();
    ex_m = '0;
    skip_m = 0;
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_valid", {31'h0, wb_valid}, 32'h0);
    chk("post_rst_ready", {31'h0, in_ready}, 32'h1);
    chk("post_rst_ex", {16'h0, ex_q}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
